// File: rtl/instr_pkg.sv
// instr_pkg: instruction classes, field positions, fetch/decode FSM states and LI sign extension
package instr_pkg;
  typedef enum logic [1:0] {CLS_ALU, CLS_LI, CLS_SYS, CLS_JMP} cls_t;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, ERR} state_t;
  localparam int CLS_LSB = 30;
  localparam int OP_LSB = 26;
  localparam int WR_LSB = 21;
  localparam int RD_LSB = 16;
  localparam int HALT_BIT = 15;
  function automatic logic [31:0] signExt16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational split of an instruction word into datapath controls
//  ir -> cls, opCode, wrReg, rdReg1, imme, selCh, selData, wrOk (write allowed), isHalt
module instr_field_decode
  import instr_pkg::*;
(
  input  logic [31:0] ir,
  output cls_t        cls,
  output logic [3:0]  opCode,
  output logic [4:0]  wrReg,
  output logic [4:0]  rdReg1,
  output logic [15:0] imme,
  output logic        selCh,
  output logic [31:0] selData,
  output logic        wrOk,
  output logic        isHalt
);
  assign cls = cls_t'(ir[CLS_LSB +: 2]);
  assign opCode = ir[OP_LSB +: 4];
  assign wrReg = ir[WR_LSB +: 5];
  assign rdReg1 = ir[RD_LSB +: 5];
  assign imme = ir[15:0];
  assign selCh = cls == CLS_LI;
  assign selData = selCh ? signExt16(imme) : '0;
  assign wrOk = (cls == CLS_ALU || cls == CLS_LI) && wrReg != '0;
  assign isHalt = cls == CLS_SYS && imme[HALT_BIT];
endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: req/ack instruction fetch, one-cycle decode/exec sequencer for the ALU datapath
//  in : clk, reset (sync, active-high), start, imem_ack, imem_rdata[31:0]
//  out: imem_req, imem_addr[PC_W-1:0], wrEnable, wrReg, rdReg1, imme, opCode, selCh, selData,
//       busy, halted, err, instr_count
//  INSTR_JUMP_EN: when defined, class 11 is a jump to imme; otherwise it is illegal.
module instr_fetch_decode
  import instr_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int RESET_PC = 0,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            wrEnable,
  output logic [4:0]      wrReg,
  output logic [4:0]      rdReg1,
  output logic [15:0]     imme,
  output logic [3:0]      opCode,
  output logic            selCh,
  output logic [31:0]     selData,
  output logic            busy,
  output logic            halted,
  output logic            err,
  output logic [15:0]     instr_count
);
`ifdef INSTR_JUMP_EN
  localparam bit jumpEn = 1'b1;
`else
  localparam bit jumpEn = 1'b0;
`endif
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t state, stateNext;
  logic [PC_W-1:0] pc;
  logic [WW-1:0] waitCnt;
  logic [15:0] instrCnt;
  logic [31:0] ir;
  cls_t cls;
  logic wrOk, isHalt, illegal, jump, retire;
  // decoded outputs come straight from ir, which only changes on the ack that enters EXEC,
  // so they are valid in EXEC and hold afterwards; ir clears on reset so they read 0
  instr_field_decode uDec (
    .ir(ir), .cls(cls), .opCode(opCode), .wrReg(wrReg), .rdReg1(rdReg1), .imme(imme),
    .selCh(selCh), .selData(selData), .wrOk(wrOk), .isHalt(isHalt)
  );
  assign illegal = !jumpEn && cls == CLS_JMP;
  assign jump = jumpEn && cls == CLS_JMP;
  assign retire = state == EXEC && !illegal;
  assign wrEnable = state == EXEC && wrOk;
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign busy = state == FETCH || state == EXEC;
  assign halted = state == HALT;
  assign err = state == ERR;
  assign instr_count = instrCnt;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = start ? FETCH : IDLE;
      FETCH:   stateNext = imem_ack ? EXEC : (waitCnt == WW'(MAX_WAIT - 1)) ? ERR : FETCH;
      EXEC:    stateNext = illegal ? ERR : isHalt ? HALT : FETCH;
      HALT:    stateNext = start ? FETCH : HALT;
      default: stateNext = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= PC_W'(RESET_PC);
      waitCnt <= '0;
      instrCnt <= '0;
      ir <= '0;
    end else begin
      state <= stateNext;
      if (state == FETCH) begin
        waitCnt <= imem_ack ? '0 : waitCnt + WW'(1);
        if (imem_ack) ir <= imem_rdata;
      end
      if (retire) begin
        instrCnt <= (instrCnt == 16'hFFFF) ? instrCnt : instrCnt + 16'd1;
        pc <= jump ? imme[PC_W-1:0] : pc + PC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: random programs served over req/ack, checked against an instruction-level model
module tb_instr_fetch_decode;
  localparam int MAX_WAIT = 15;
`ifdef INSTR_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, wrEnable, selCh, busy, halted, err;
  logic [7:0] imem_addr;
  logic [4:0] wrReg, rdReg1;
  logic [15:0] imme, instr_count;
  logic [3:0] opCode;
  logic [31:0] selData;
  int total = 0, bad = 0;
  int mpc = 0, mcnt = 0, mode = 0;
  logic [31:0] lastW = '0;

  always #5 clk = ~clk;

  instr_fetch_decode dut (
    .clk(clk), .reset(reset), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .wrEnable(wrEnable), .wrReg(wrReg),
    .rdReg1(rdReg1), .imme(imme), .opCode(opCode), .selCh(selCh), .selData(selData),
    .busy(busy), .halted(halted), .err(err), .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] expSelData(input logic [31:0] w);
    return (w[31:30] == 2'b01) ? 32'($signed(w[15:0])) : 32'd0;
  endfunction

  task automatic checkFields(input string tag, input logic [31:0] w, input bit inExec);
    check({tag, ".we"}, 32'(wrEnable), 32'(inExec && w[31:30] < 2'd2 && w[25:21] != 5'd0));
    check({tag, ".wrReg"}, 32'(wrReg), 32'(w[25:21]));
    check({tag, ".rdReg1"}, 32'(rdReg1), 32'(w[20:16]));
    check({tag, ".opCode"}, 32'(opCode), 32'(w[29:26]));
    check({tag, ".imme"}, 32'(imme), 32'(w[15:0]));
    check({tag, ".selCh"}, 32'(selCh), 32'(w[31:30] == 2'b01));
    check({tag, ".selData"}, selData, expSelData(w));
  endtask

  // mode: 0 fetching, 1 halted, 2 error, 3 idle
  task automatic checkStatus(input string tag);
    check({tag, ".req"}, 32'(imem_req), 32'(mode == 0));
    check({tag, ".busy"}, 32'(busy), 32'(mode == 0));
    check({tag, ".halted"}, 32'(halted), 32'(mode == 1));
    check({tag, ".err"}, 32'(err), 32'(mode == 2));
    check({tag, ".count"}, 32'(instr_count), 32'(mcnt));
    if (mode != 2) check({tag, ".addr"}, 32'(imem_addr), 32'(mpc));
  endtask

  task automatic runInstr(input logic [31:0] w, input int delay);
    checkStatus("fetch");
    for (int k = 1; k <= delay; k++) begin
      start = 1'($urandom_range(0, 1));
      tick;
      if (k == MAX_WAIT) begin
        start = 1'b0;
        mode = 2;
        checkStatus("timeout");
        checkFields("timeout", lastW, 1'b0);
        return;
      end
      checkStatus("wait");
      checkFields("wait", lastW, 1'b0);
    end
    start = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = w;
    tick;
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    lastW = w;
    checkFields("exec", w, 1'b1);
    check("exec.busy", 32'(busy), 32'd1);
    check("exec.req", 32'(imem_req), 32'd0);
    if (w[31:30] == 2'b11 && !JUMP_EN) mode = 2;
    else begin
      mcnt = (mcnt == 65535) ? mcnt : mcnt + 1;
      mpc = (w[31:30] == 2'b11) ? int'(w[7:0]) : (mpc + 1) % 256;
      if (w[31:30] == 2'b10 && w[15]) mode = 1;
    end
    tick;
    checkStatus("post");
    checkFields("post", w, 1'b0);
  endtask

  task automatic restart;
    imem_ack = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    mpc = 0;
    mcnt = 0;
    mode = 3;
    lastW = '0;
    checkStatus("rst");
    checkFields("rst", lastW, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    mode = 0;
  endtask

  // after halt/error: prove the state is sticky, then resume or reset
  task automatic recover;
    if (mode == 1) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        imem_ack = 1'($urandom_range(0, 1));
        tick;
        checkStatus("halt");
        checkFields("halt", lastW, 1'b0);
      end
      imem_ack = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      mode = 0;
    end else if (mode == 2) begin
      for (int i = 0; i < 3; i++) begin
        imem_ack = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        tick;
        checkStatus("errHold");
        checkFields("errHold", lastW, 1'b0);
      end
      restart;
    end
  endtask

  function automatic logic [31:0] randWord(input bit allowStop);
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 99);
    w[31:30] = r < 40 ? 2'b00 : r < 70 ? 2'b01 : r < 90 ? 2'b10 : 2'b11;
    if (!allowStop && w[31:30] == 2'b11 && !JUMP_EN) w[31:30] = 2'b00;
    if (!allowStop && w[31:30] == 2'b10) w[15] = 1'b0;
    if ($urandom_range(0, 5) == 0) w[25:21] = 5'd0;
    return w;
  endfunction

  initial begin
    tick;
    tick;
    mode = 3;
    checkStatus("reset");
    checkFields("reset", lastW, 1'b0);
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h44A3_1234;
    tick;
    imem_ack = 1'b0;
    checkStatus("idleAck");
    checkFields("idleAck", lastW, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    mode = 0;
    runInstr(32'h04A3_0000, 0);
    runInstr({2'b01, 4'h0, 5'd2, 5'd0, 16'h8001}, 2);
    runInstr({2'b00, 4'h3, 5'd0, 5'd7, 16'h0055}, 1);
    runInstr(32'h8000_8000, 0);
    recover;
    runInstr({2'b11, 4'h0, 5'd1, 5'd0, 16'h0020}, 0);
    recover;
    for (int i = 0; i < 260; i++) runInstr(randWord(1'b0), $urandom_range(0, 2));
    runInstr(randWord(1'b0), MAX_WAIT - 1);
    runInstr(randWord(1'b0), MAX_WAIT);
    recover;
    for (int i = 0; i < 400; i++) begin
      runInstr(randWord(1'b1), ($urandom_range(0, 19) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3));
      recover;
    end
    runInstr(randWord(1'b0), 0);
    tick;
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h44A3_FFFF;
    tick;
    reset = 1'b0;
    tick;
    imem_ack = 1'b0;
    mpc = 0;
    mcnt = 0;
    mode = 3;
    lastW = '0;
    checkStatus("midFetchRst");
    checkFields("midFetchRst", lastW, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
